lods_sched_12: RTL and testbench
================================

// Module: lods_sched_12
// PURPOSE
//  Grant scheduler for up to 12 requesters sharing a single downstream resource.
//  Picks the winner with the 12-bit leading-one detector: bit 11 has the highest priority.
//  Issues a valid/ready grant, holds the resource until the owner signals done or the hold times out.
//  Sits between request sources and the shared unit; one grant outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYC  255  max BUSY cycles before forced release; 0 disables timeout (8-bit counter)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  req         in   12  level request per requester; bit i = requester i
//  gnt_ready   in   1   downstream accepts current grant
//  done        in   1   one-cycle pulse: granted owner releases resource
//  gnt_valid   out  1   grant offer valid (GRANT state)
//  gnt_idx     out  4   winner index 0..11, stable while gnt_valid or busy
//  gnt_onehot  out  12  one-hot of gnt_idx while gnt_valid|busy, else 0
//  busy        out  1   resource owned (BUSY state)
//  timeout     out  1   one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0, timeout=0,
//   counter=0, rr pointer=0. All outputs registered.
//  FSM IDLE -> GRANT -> BUSY -> IDLE:
//   IDLE : if |req_eff, latch gnt_idx = leading-one index of req_eff; next GRANT. Else stay.
//   GRANT: gnt_valid=1; gnt_idx frozen, req changes ignored (no re-arbitration, no withdrawal).
//          gnt_valid & gnt_ready -> BUSY next cycle, gnt_valid drops same edge.
//   BUSY : busy=1; counter increments each cycle from 0. done=1 -> IDLE.
//          TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 with done=0 -> IDLE, timeout pulses 1 cycle.
//          done and timeout condition same cycle -> done wins, no timeout pulse.
//  Latency: req seen in IDLE at edge N -> gnt_valid high after edge N (visible cycle N+1).
//  Turnaround: leaving BUSY always passes through IDLE one cycle; min request-to-request = 3 cycles.
//  done outside BUSY ignored. gnt_ready outside GRANT ignored.
//  Counter saturates at 255 when TIMEOUT_CYC=0; cleared on entering BUSY.
//  req_eff: req (fixed priority) unless CONFIGURATION below applies.
//  Reset asserted mid-GRANT/BUSY: immediate return to reset values, no timeout pulse.
// CONFIGURATION
//  LODS_SCHED_RR_EN defined: round-robin. rr pointer = last granted idx (updated on GRANT->BUSY).
//   req_eff = req & mask of bits strictly below pointer; if that is 0, req_eff = req (wrap to 11).
//  Not defined: fixed priority, req_eff = req, pointer logic absent.
// STRUCTURE
//  Shared package lods_sched_pkg: typedef enum logic[1:0] {S_IDLE, S_GRANT, S_BUSY};
//   localparams N_REQ=12, IDX_W=4; typedef logic[N_REQ-1:0] req_vec_t.
//  One sub-module: single lods_12 instance (12-bit leading-one detector, c=index, v=any)
//   fed by req_eff; everything else in this module.
// TESTING
//  1 req=0x000 for 20 cycles -> gnt_valid=0, busy=0, gnt_onehot=0 throughout.
//  2 req=0x024 -> cycle+1 gnt_valid=1, gnt_idx=5, gnt_onehot=0x020; gnt_ready=1 -> busy=1; done -> IDLE.
//  3 In GRANT idx=5, change req to 0x800, gnt_ready=0 for 10 cycles -> gnt_idx stays 5, gnt_valid stays 1.
//  4 TIMEOUT_CYC=4, grant taken, no done -> busy exactly 4 cycles, timeout=1 one cycle, then IDLE.
//    Repeat with done on 4th busy cycle -> timeout=0.
//  5 rst_n=0 mid-BUSY -> all outputs 0 asynchronously, next grant re-arbitrates from IDLE.
//  6 RR_EN, req=0x801 held, done each grant -> idx sequence 11,0,11,0; without RR_EN -> 11,11,11.

Source files
------------

// File: rtl/lods_sched_pkg.sv
// Shared types and helpers for the 12-requester grant scheduler.
// Holds the FSM encoding, request vector type and one-hot/mask helpers.
package lods_sched_pkg;

  localparam int N_REQ = 12;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_BUSY  = 2'b10
  } state_t;

  typedef logic [N_REQ-1:0] req_vec_t;

  function automatic req_vec_t idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Bits strictly below idx; idx=0 yields an empty mask.
  function automatic req_vec_t below_mask(input logic [IDX_W-1:0] idx);
    return idx_to_onehot(idx) - {{(N_REQ-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lods_sched_12_lods.sv
// 12-bit leading-one detector: o_c is the index of the highest set bit,
// o_v flags that any bit is set.
module lods_12
  import lods_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_c,
  output logic             o_v
);

  assign o_v = |i_vec;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    o_c = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      o_c = i_vec[i] ? IDX_W'(i) : o_c;
    end
  end

endmodule

// File: rtl/lods_sched_12.sv
// Grant scheduler: 12 requesters, one shared resource, IDLE->GRANT->BUSY->IDLE.
// Define LODS_SCHED_RR_EN for round-robin arbitration; default is fixed priority (bit 11 highest).
module lods_sched_12
  import lods_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              gnt_ready,
  input  logic              done,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [N_REQ-1:0]  gnt_onehot,
  output logic              busy,
  output logic              timeout
);

  localparam bit         TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_lod_idx;
  logic             w_lod_any;
  req_vec_t         w_req_eff;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             w_tmo_nxt;
  logic             r_gnt_valid;
  logic             r_busy;
  logic             r_timeout;
  req_vec_t         r_onehot;

`ifdef LODS_SCHED_RR_EN
  logic [IDX_W-1:0] r_ptr;
  req_vec_t         w_req_masked;

  // Prefer requesters below the last owner; wrap to the full vector when none.
  always_comb begin
    w_req_masked = req & below_mask(r_ptr);
    if (|w_req_masked) begin
      w_req_eff = w_req_masked;
    end else begin
      w_req_eff = req;
    end
  end

  // Pointer follows the owner at the moment the grant is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= {IDX_W{1'b0}};
    end else if (r_state == S_GRANT && gnt_ready) begin
      r_ptr <= r_gnt_idx;
    end
  end
`else
  assign w_req_eff = req;
`endif

  lods_12 u_lods (
    .i_vec (w_req_eff),
    .o_c   (w_lod_idx),
    .o_v   (w_lod_any)
  );

  // Next-state, winner latch, hold counter and forced-release decision.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_gnt_idx;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lod_any) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_lod_idx;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (gnt_ready) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      S_BUSY: begin
        if (done) begin
          w_state_nxt = S_IDLE;
        end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = (r_cnt != 8'hFF) ? (r_cnt + 8'd1) : r_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_cnt       <= 8'd0;
      r_gnt_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_onehot    <= {N_REQ{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt_valid <= (w_state_nxt == S_GRANT);
      r_busy      <= (w_state_nxt == S_BUSY);
      r_timeout   <= w_tmo_nxt;
      r_onehot    <= (w_state_nxt == S_GRANT || w_state_nxt == S_BUSY) ?
                     idx_to_onehot(w_idx_nxt) : {N_REQ{1'b0}};
    end
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = r_onehot;
  assign busy       = r_busy;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_lods_sched_12.sv
// Scoreboard bench for lods_sched_12 (TIMEOUT_CYC=4): grant/release events are
// queued at stimulus time and checked by an independent negedge monitor.
module tb_lods_sched_12;

  typedef struct {
    bit          kind;   // 0 = grant offered, 1 = resource released
    logic [3:0]  idx;
    logic [11:0] oh;
    logic        tmo;
    int          bcyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] req;
  logic        gnt_ready;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [11:0] gnt_onehot;
  logic        busy;
  logic        timeout;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  int   lat;

  lods_sched_12 #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_grant(input logic [3:0] idx, input logic [11:0] oh);
    exp_t e;
    e.kind = 1'b0; e.idx = idx; e.oh = oh; e.tmo = 1'b0; e.bcyc = 0;
    q.push_back(e);
  endtask

  task automatic push_release(input logic tmo, input int bcyc);
    exp_t e;
    e.kind = 1'b1; e.idx = 4'd0; e.oh = 12'h000; e.tmo = tmo; e.bcyc = bcyc;
    q.push_back(e);
  endtask

  // Monitor: grant event on gnt_valid rise, release event on busy fall.
  initial begin
    logic prev_v;
    logic prev_b;
    int   bcnt;
    exp_t e;
    prev_v = 1'b0;
    prev_b = 1'b0;
    bcnt   = 0;
    forever begin
      @(negedge clk);
      if (gnt_valid === 1'b1 && !prev_v) begin
        if (q.size() == 0) begin
          check("unexpected_grant", {28'd0, gnt_idx}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("grant_kind", 32'(e.kind), 32'd0);
          check("grant_idx", {28'd0, gnt_idx}, {28'd0, e.idx});
          check("grant_onehot", {20'd0, gnt_onehot}, {20'd0, e.oh});
        end
      end
      if (busy === 1'b1) bcnt++;
      if (busy !== 1'b1 && prev_b) begin
        if (q.size() == 0) begin
          check("unexpected_release", 32'(bcnt), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("release_kind", 32'(e.kind), 32'd1);
          check("release_timeout", {31'd0, timeout}, {31'd0, e.tmo});
          check("busy_cycles", 32'(bcnt), 32'(e.bcyc));
        end
        bcnt = 0;
      end
      prev_v = (gnt_valid === 1'b1);
      prev_b = (busy === 1'b1);
    end
  end

  // One full transaction: request, accept, then done after done_at busy cycles or wait for timeout.
  task automatic run_txn(input logic [11:0] r, input logic [3:0] eidx, input int done_at,
                         input int eb, input logic etmo, input bit keep, output int l);
    int w;
    push_grant(eidx, 12'h001 << eidx);
    push_release(etmo, eb);
    req = r;
    l = -1;
    for (int k = 0; k < 10; k++) begin
      if (gnt_valid) begin
        l = k;
        break;
      end
      cyc(1);
    end
    check("grant_seen", {31'd0, (l >= 0)}, 32'd1);
    if (!keep) req = 12'h000;
    gnt_ready = 1'b1;
    cyc(1);
    gnt_ready = 1'b0;
    check("busy_after_accept", {30'd0, gnt_valid, busy}, 32'd1);
    if (done_at > 0) begin
      cyc(done_at - 1);
      done = 1'b1;
      cyc(1);
      done = 1'b0;
    end else begin
      w = 0;
      while (busy && w < 300) begin
        cyc(1);
        w++;
      end
      check("release_bound", {31'd0, busy}, 32'd0);
    end
    cyc(1);
    check("timeout_one_cycle", {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req = 12'h000;
    gnt_ready = 1'b0;
    done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
    check("rst_gnt_idx", {28'd0, gnt_idx}, 32'd0);
    check("rst_onehot", {20'd0, gnt_onehot}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;

    // No requests: nothing may be granted.
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_quiet", {18'd0, gnt_valid, busy, gnt_onehot}, 32'd0);
    end

    // 0x024: bit 5 wins over bit 2; done on the 2nd busy cycle.
    run_txn(12'h024, 4'd5, 2, 2, 1'b0, 1'b0, lat);
    check("grant_latency", 32'(lat), 32'd1);

    // Grant frozen while the offer is pending, despite a higher request appearing.
    push_grant(4'd5, 12'h020);
    push_release(1'b0, 1);
    req = 12'h020;
    cyc(1);
    check("t3_offer", {31'd0, gnt_valid}, 32'd1);
    req = 12'h800;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t3_hold", {27'd0, gnt_valid, gnt_idx}, 32'h15);
    end
    check("t3_onehot", {20'd0, gnt_onehot}, 32'h020);
    req = 12'h000;
    gnt_ready = 1'b1;
    cyc(1);
    gnt_ready = 1'b0;
    check("t3_busy", {31'd0, busy}, 32'd1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(2);

    // Timeout after 4 busy cycles; then done on the 4th cycle beats the timeout.
    run_txn(12'h100, 4'd8, 0, 4, 1'b1, 1'b0, lat);
    run_txn(12'h100, 4'd8, 4, 4, 1'b0, 1'b0, lat);

    // Async reset while busy, then a fresh arbitration.
    push_grant(4'd4, 12'h010);
    push_release(1'b0, 1);
    req = 12'h010;
    cyc(1);
    gnt_ready = 1'b1;
    req = 12'h000;
    cyc(1);
    gnt_ready = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {17'd0, gnt_valid, busy, timeout, gnt_onehot}, 32'd0);
    check("t5_idx_clear", {28'd0, gnt_idx}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    run_txn(12'h024, 4'd5, 1, 1, 1'b0, 1'b0, lat);
    check("t5_regrant_latency", 32'(lat), 32'd1);

    // Two requesters held across back-to-back grants, starting from a fresh pointer.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
`ifdef LODS_SCHED_RR_EN
    run_txn(12'h801, 4'd11, 1, 1, 1'b0, 1'b1, lat);
    run_txn(12'h801, 4'd0,  1, 1, 1'b0, 1'b1, lat);
    run_txn(12'h801, 4'd11, 1, 1, 1'b0, 1'b1, lat);
    run_txn(12'h801, 4'd0,  1, 1, 1'b0, 1'b0, lat);
`else
    run_txn(12'h801, 4'd11, 1, 1, 1'b0, 1'b1, lat);
    run_txn(12'h801, 4'd11, 1, 1, 1'b0, 1'b1, lat);
    run_txn(12'h801, 4'd11, 1, 1, 1'b0, 1'b0, lat);
`endif

    cyc(5);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
